// File: rtl/boot_seq_ctrl_if.sv
// Loader byte stream and unified-memory write port of the boot sequencer.
// The master side is the sequencer; the slave side is the loader/memory.
interface boot_seq_ctrl_if #(
    parameter int MEM_AW = 16
);
    logic              byte_valid_i;
    logic [7:0]        byte_data_i;
    logic              byte_ready_o;
    logic              mem_req_o;
    logic [MEM_AW-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic [3:0]        mem_be_o;
    logic              mem_gnt_i;

    modport master (
        input  byte_valid_i, byte_data_i, mem_gnt_i,
        output byte_ready_o, mem_req_o, mem_addr_o, mem_wdata_o, mem_be_o
    );

    modport slave (
        output byte_valid_i, byte_data_i, mem_gnt_i,
        input  byte_ready_o, mem_req_o, mem_addr_o, mem_wdata_o, mem_be_o
    );
endinterface

// File: rtl/boot_seq_ctrl.sv
// Boot/run sequencer: loads a memory image from a byte stream, releases
// core reset, then watches the end-of-test bit under a cycle timeout.
module boot_seq_ctrl #(
    parameter int          MEM_AW   = 16,
    parameter int          RST_HOLD = 16,
    parameter logic [31:0] TIMEOUT  = 32'd50_000_000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    boot_seq_ctrl_if.master        bus,
    input  logic                   done_i,
    output logic                   core_rst_no,
    output logic                   busy_o,
    output logic                   pass_o,
    output logic                   fail_o,
    output logic [1:0]             err_code_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_DATA, S_WRITE,
        S_HOLD, S_RUN, S_PASS, S_FAIL
    } state_e;

    state_e            state_q;
    logic [63:0]       shift_q;
    logic [2:0]        bcnt_q;
    logic [31:0]       rem_q;
    logic [31:0]       hold_q;
    logic [31:0]       tmo_q;
    logic              rdy_q;
    logic              req_q;
    logic [MEM_AW-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;
    logic              crst_n_q;
    logic              busy_q;
    logic              pass_q;
    logic              fail_q;
    logic [1:0]        err_q;

    logic [63:0]       shift_d;
    logic [31:0]       hdr_a;
    logic [31:0]       hdr_n;
    logic [33:0]       span;
    logic              hdr_bad;
    logic              accept;
    logic              hold_done;
    logic              tmo_hit;

    // Bytes enter at the top, so after 8 shifts byte 0 sits in [7:0].
    always_comb begin
        shift_d   = {bus.byte_data_i, shift_q[63:8]};
        hdr_a     = shift_d[31:0];
        hdr_n     = shift_d[63:32];
        span      = {4'b0, hdr_a[31:2]} + {2'b0, hdr_n};
        hdr_bad   = (hdr_a[1:0] != 2'b00) || (span > (34'd1 << MEM_AW));
        accept    = rdy_q & bus.byte_valid_i;
        hold_done = (hold_q + 32'd1) >= 32'(RST_HOLD);
        tmo_hit   = (TIMEOUT != 32'd0) && (tmo_q == TIMEOUT - 32'd1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            shift_q  <= '0;
            bcnt_q   <= '0;
            rem_q    <= '0;
            hold_q   <= '0;
            tmo_q    <= '0;
            rdy_q    <= 1'b0;
            req_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            crst_n_q <= 1'b0;
            busy_q   <= 1'b0;
            pass_q   <= 1'b0;
            fail_q   <= 1'b0;
            err_q    <= '0;
        end else begin
            unique case (state_q)
                S_IDLE, S_PASS, S_FAIL: begin
                    if (start_i) begin
                        state_q  <= S_HDR;
                        bcnt_q   <= '0;
                        rdy_q    <= 1'b1;
                        busy_q   <= 1'b1;
                        crst_n_q <= 1'b0;
                        pass_q   <= 1'b0;
                        fail_q   <= 1'b0;
                        err_q    <= '0;
                    end
                end
                S_HDR: begin
                    if (accept) begin
                        shift_q <= shift_d;
                        bcnt_q  <= bcnt_q + 3'd1;
                        if (bcnt_q == 3'd7) begin
                            bcnt_q <= '0;
                            if (hdr_bad) begin
                                state_q <= S_FAIL;
                                rdy_q   <= 1'b0;
                                busy_q  <= 1'b0;
                                fail_q  <= 1'b1;
                                err_q   <= 2'd1;
                            end else if (hdr_n == 32'd0) begin
                                state_q <= S_HOLD;
                                rdy_q   <= 1'b0;
                                hold_q  <= '0;
                            end else begin
                                state_q <= S_DATA;
                                addr_q  <= hdr_a[MEM_AW+1:2];
                                rem_q   <= hdr_n;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        shift_q <= shift_d;
                        bcnt_q  <= bcnt_q + 3'd1;
                        if (bcnt_q[1:0] == 2'd3) begin
                            state_q <= S_WRITE;
                            rdy_q   <= 1'b0;
                            req_q   <= 1'b1;
                            be_q    <= 4'hF;
                            wdata_q <= shift_d[63:32];
                        end
                    end
                end
                S_WRITE: begin
                    if (bus.mem_gnt_i) begin
                        req_q  <= 1'b0;
                        be_q   <= '0;
                        addr_q <= addr_q + 1'b1;
                        rem_q  <= rem_q - 32'd1;
                        if (rem_q == 32'd1) begin
                            state_q <= S_HOLD;
                            hold_q  <= '0;
                        end else begin
                            state_q <= S_DATA;
                            rdy_q   <= 1'b1;
                            bcnt_q  <= '0;
                        end
                    end
                end
                S_HOLD: begin
                    hold_q <= hold_q + 32'd1;
                    if (hold_done) begin
                        state_q  <= S_RUN;
                        crst_n_q <= 1'b1;
                        tmo_q    <= '0;
                    end
                end
                S_RUN: begin
                    tmo_q <= tmo_q + 32'd1;
                    // A simultaneous done and timeout counts as a pass.
                    if (done_i) begin
                        state_q <= S_PASS;
                        busy_q  <= 1'b0;
                        pass_q  <= 1'b1;
                    end else if (tmo_hit) begin
                        state_q  <= S_FAIL;
                        busy_q   <= 1'b0;
                        fail_q   <= 1'b1;
                        err_q    <= 2'd2;
                        crst_n_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.byte_ready_o = rdy_q;
    assign bus.mem_req_o    = req_q;
    assign bus.mem_addr_o   = addr_q;
    assign bus.mem_wdata_o  = wdata_q;
    assign bus.mem_be_o     = be_q;
    assign core_rst_no      = crst_n_q;
    assign busy_o           = busy_q;
    assign pass_o           = pass_q;
    assign fail_o           = fail_q;
    assign err_code_o       = err_q;

endmodule

// File: tb/tb_boot_seq_ctrl.sv
// Scoreboard bench for boot_seq_ctrl: random images, a queue-based model
// of expected writes and outcomes, and a decoupled negedge monitor.
module tb_boot_seq_ctrl;
    localparam int          AW   = 16;
    localparam int          HOLD = 16;
    localparam logic [31:0] TMO  = 32'd1000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_i = 1'b0;
    logic       done_i = 1'b0;
    logic       core_rst_no;
    logic       busy_o;
    logic       pass_o;
    logic       fail_o;
    logic [1:0] err_code_o;

    boot_seq_ctrl_if #(.MEM_AW(AW)) bus ();

    boot_seq_ctrl #(
        .MEM_AW  (AW),
        .RST_HOLD(HOLD),
        .TIMEOUT (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .bus        (bus),
        .done_i     (done_i),
        .core_rst_no(core_rst_no),
        .busy_o     (busy_o),
        .pass_o     (pass_o),
        .fail_o     (fail_o),
        .err_code_o (err_code_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    typedef struct {
        bit       pass;
        bit       fail;
        logic [1:0] err;
        bit       tmo;
    } res_t;

    wr_t  wq[$];
    res_t rq[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int gnt_delay = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"}, bus.byte_ready_o, 0);
        chk({tag, "_req"},   bus.mem_req_o, 0);
        chk({tag, "_addr"},  bus.mem_addr_o, 0);
        chk({tag, "_wdata"}, bus.mem_wdata_o, 0);
        chk({tag, "_be"},    bus.mem_be_o, 0);
        chk({tag, "_crstn"}, core_rst_no, 0);
        chk({tag, "_busy"},  busy_o, 0);
        chk({tag, "_pass"},  pass_o, 0);
        chk({tag, "_fail"},  fail_o, 0);
        chk({tag, "_err"},   err_code_o, 0);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory grant responder: grant after gnt_delay waiting cycles.
    initial begin
        int age;
        age = 0;
        bus.mem_gnt_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.mem_req_o === 1'b1 && !rst) begin
                bus.mem_gnt_i = (age >= gnt_delay);
                age++;
            end else begin
                bus.mem_gnt_i = 1'b0;
                age = 0;
            end
        end
    end

    // Monitor: pops expected writes and outcomes as the DUT presents them.
    initial begin
        bit            prev_req, prev_gnt, prev_crst, prev_term;
        logic [AW-1:0] prev_addr;
        logic [31:0]   prev_wdata;
        int            last_act, rise_cyc;
        wr_t           w;
        res_t          r;
        prev_req = 0; prev_gnt = 0; prev_crst = 0; prev_term = 0;
        prev_addr = '0; prev_wdata = '0;
        last_act = 0; rise_cyc = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_req = 0; prev_gnt = 0; prev_crst = 0; prev_term = 0;
            end else begin
                if (bus.byte_valid_i && bus.byte_ready_o)
                    last_act = cyc;
                if (bus.mem_req_o) begin
                    if (prev_req && !prev_gnt) begin
                        chk("addr_stable", bus.mem_addr_o, prev_addr);
                        chk("wdata_stable", bus.mem_wdata_o, prev_wdata);
                    end
                    if ((!prev_req || prev_gnt) && wq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_req addr=%0h data=%0h",
                                 bus.mem_addr_o, bus.mem_wdata_o);
                    end
                    if (bus.mem_gnt_i && wq.size() != 0) begin
                        w = wq.pop_front();
                        chk("wr_addr", bus.mem_addr_o, w.addr);
                        chk("wr_data", bus.mem_wdata_o, w.data);
                        chk("wr_be", bus.mem_be_o, 4'hF);
                        last_act = cyc;
                    end
                end
                if (core_rst_no && !prev_crst) begin
                    rise_cyc = cyc;
                    chk("hold_len", cyc - last_act, HOLD + 1);
                end
                if ((pass_o || fail_o) && !prev_term) begin
                    if (rq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_end pass=%0d fail=%0d",
                                 pass_o, fail_o);
                    end else begin
                        r = rq.pop_front();
                        chk("res_pass", pass_o, r.pass);
                        chk("res_fail", fail_o, r.fail);
                        chk("res_err", err_code_o, r.err);
                        chk("res_crstn", core_rst_no, r.pass);
                        chk("res_busy", busy_o, 0);
                        if (r.tmo)
                            chk("run_len", cyc - rise_cyc, TMO);
                    end
                end
                prev_req   = bus.mem_req_o;
                prev_gnt   = bus.mem_gnt_i;
                prev_addr  = bus.mem_addr_o;
                prev_wdata = bus.mem_wdata_o;
                prev_crst  = core_rst_no;
                prev_term  = pass_o || fail_o;
            end
        end
    end

    function automatic int gapv(input int mode);
        if (mode == 0) return 0;
        if (mode == 1) return 1;
        return int'($urandom_range(0, 2));
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit acc;
        int n;
        repeat (gap) begin
            bus.byte_valid_i = 1'b0;
            @(posedge clk);
            #1;
        end
        bus.byte_valid_i = 1'b1;
        bus.byte_data_i  = b;
        acc = 0;
        n = 0;
        while (!acc && n < 2000) begin
            @(negedge clk);
            acc = bus.byte_ready_o;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL byte_accept_timeout actual=0 expected=1");
        end
    endtask

    task automatic pulse_start;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    task automatic wait_cond_rise(output bit ok);
        int k;
        k = 0;
        while (!core_rst_no && k < 5000) begin
            @(posedge clk);
            #1;
            k++;
        end
        ok = core_rst_no;
    endtask

    // dmode: 0 done after dly cycles, 1 never, 2 on the last RUN cycle
    task automatic run_boot(input logic [31:0] a, input logic [31:0] n,
                            input int gap, input int gdly, input int dmode,
                            input int dly, input bit poke,
                            input logic [31:0] w0, input logic [31:0] w1);
        bit          bad, ok;
        res_t        r;
        wr_t         e;
        logic [31:0] wds[$];
        logic [31:0] t;
        logic [31:0] w;
        int          k;
        bad = (a % 4 != 0) ||
              (longint'(a >> 2) + longint'(n) > (longint'(1) << AW));
        gnt_delay = gdly;
        if (bad) begin
            r.pass = 0; r.fail = 1; r.err = 2'd1; r.tmo = 0;
        end else if (dmode == 1) begin
            r.pass = 0; r.fail = 1; r.err = 2'd2; r.tmo = 1;
        end else begin
            r.pass = 1; r.fail = 0; r.err = 2'd0; r.tmo = 0;
        end
        rq.push_back(r);
        if (!bad) begin
            for (int i = 0; i < int'(n); i++) begin
                w = (i == 0) ? w0 : (i == 1) ? w1 : $urandom;
                wds.push_back(w);
                t = (a >> 2) + 32'(i);
                e.addr = t[AW-1:0];
                e.data = w;
                wq.push_back(e);
            end
        end
        pulse_start();
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], gapv(gap));
        for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8], gapv(gap));
        foreach (wds[j]) begin
            w = wds[j];
            for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gapv(gap));
        end
        bus.byte_valid_i = 1'b0;
        if (!bad) begin
            wait_cond_rise(ok);
            if (!ok) begin
                checks++;
                errors++;
                $display("FAIL release_timeout actual=0 expected=1");
            end
            if (poke) begin
                pulse_start();
                @(posedge clk);
                #1;
                chk("poke_busy", busy_o, 1);
                chk("poke_crstn", core_rst_no, 1);
                chk("poke_ready", bus.byte_ready_o, 0);
            end
            if (dmode == 0) begin
                repeat (dly) @(posedge clk);
                #1;
                done_i = 1'b1;
                @(posedge clk);
                #1;
                done_i = 1'b0;
            end else if (dmode == 2) begin
                repeat (int'(TMO) - 1) @(posedge clk);
                #1;
                done_i = 1'b1;
                @(posedge clk);
                #1;
                done_i = 1'b0;
            end
        end
        k = 0;
        while (!(pass_o || fail_o) && k < int'(TMO) + 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!(pass_o || fail_o)) begin
            checks++;
            errors++;
            $display("FAIL end_timeout actual=0 expected=1");
        end
        repeat (2) @(posedge clk);
        #1;
        chk("wq_drained", wq.size(), 0);
        chk("rq_drained", rq.size(), 0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] hdr;
        wr_t         e;
        int          k;
        bus.byte_valid_i = 1'b0;
        bus.byte_data_i  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("por");
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_busy", busy_o, 0);
        chk("idle_crstn", core_rst_no, 0);

        run_boot(32'h100, 2, 0, 0, 0, 100, 0, 32'hDEADBEEF, 32'h12345678);
        run_boot(32'h100, 2, 1, 3, 0, 100, 0, 32'hDEADBEEF, 32'h12345678);
        run_boot(32'h102, 2, 0, 0, 0, 10, 0, 32'h0, 32'h0);
        run_boot(32'((2 ** AW - 1) * 4), 2, 0, 0, 0, 10, 0, 32'h0, 32'h0);
        run_boot(32'h400, 3, 2, 2, 1, 0, 0, $urandom, $urandom);
        run_boot(32'h0, 1, 0, 0, 2, 0, 0, 32'hA5A5_5A5A, 32'h0);
        run_boot(32'h80, 0, 0, 0, 0, 20, 1, 32'h0, 32'h0);
        run_boot(32'((2 ** AW - 3) * 4), 3, 2, 1, 0, 5, 0, $urandom, $urandom);

        for (int it = 0; it < 8; it++) begin
            if ($urandom_range(0, 3) == 0)
                a = $urandom;
            else
                a = 32'($urandom_range(0, 2 ** AW - 8)) << 2;
            run_boot(a, 32'($urandom_range(0, 5)), 2,
                     int'($urandom_range(0, 4)), 0,
                     int'($urandom_range(0, 300)), 0, $urandom, $urandom);
        end

        // Abort mid-write with the request still waiting for its grant.
        gnt_delay = 50;
        e.addr = 16'h0080;
        e.data = 32'hCAFE_F00D;
        wq.push_back(e);
        pulse_start();
        a = 32'h200;
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], 0);
        hdr = 32'd2;
        for (int i = 0; i < 4; i++) send_byte(hdr[8*i +: 8], 0);
        for (int i = 0; i < 4; i++) send_byte(e.data[8*i +: 8], 0);
        bus.byte_valid_i = 1'b0;
        k = 0;
        while (!bus.mem_req_o && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("abort_req_before", bus.mem_req_o, 1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_reset("abort");
        wq.delete();
        rq.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_boot(32'h40, 3, 2, 1, 0, 50, 0, $urandom, $urandom);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "global timeout");
    end

endmodule
